// File: rtl/toast_mem_arbiter_pkg.sv
// Shared types and constants for the ToastCore memory-port arbiter.
package toast_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_t;

  localparam int ARB_LAT_W = 2;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : (v + 4'd1);
  endfunction

endpackage

// File: rtl/toast_mem_arbiter_if.sv
// Fetch, data and memory bus signals of the ToastCore memory-port arbiter.
interface toast_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_flush;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  logic              d_req_valid;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_we;
  logic [DATA_W-1:0] d_req_wdata;
  logic [3:0]        d_req_wstrb;
  logic              d_req_ready;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [3:0]        mem_wr_strb;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  if_req_valid, if_req_addr, if_flush,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
    input  mem_rd_data,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_strb, mem_wr_data
  );

  modport master (
    output if_req_valid, if_req_addr, if_flush,
    output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
    output mem_rd_data,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_strb, mem_wr_data
  );
endinterface

// File: rtl/toast_mem_arbiter.sv
// Shares the single memory port between fetch and data, data first, one transaction in flight.
// Optional IF starvation guard enabled by defining TOAST_ARB_STARVE_GUARD_EN.
module toast_mem_arbiter
  import toast_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  toast_mem_arbiter_if.slave  bus,
  output logic                busy
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("toast_mem_arbiter: DATA_W must be 32");
  end
  if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_rd_lat
    $error("toast_mem_arbiter: RD_LAT must be 1..4");
  end
  if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve
    $error("toast_mem_arbiter: STARVE_MAX must be 1..15");
  end

  localparam logic [ARB_LAT_W-1:0] LAT_INIT = ARB_LAT_W'(RD_LAT - 1);
  localparam logic [ARB_LAT_W-1:0] LAT_ZERO = ARB_LAT_W'(0);
  localparam logic [ARB_LAT_W-1:0] LAT_ONE  = ARB_LAT_W'(1);

  arb_state_t            state_r, state_nxt_s;
  arb_owner_t            owner_r;
  logic                  we_r, kill_r;
  logic [ARB_LAT_W-1:0]  lat_cnt_r;
  logic                  grant_if_s, grant_d_s, accept_s, d_wr_s, to_resp_s, starve_force_s;
  logic [ADDR_W-1:0]     mem_addr_r;
  logic                  mem_rd_en_r, mem_wr_en_r;
  logic [3:0]            mem_wr_strb_r;
  logic [DATA_W-1:0]     mem_wr_data_r, if_rsp_data_r, d_rsp_data_r;
  logic                  if_rsp_valid_r, d_rsp_valid_r;

`ifdef TOAST_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_r;

  // Count data grants made while a fetch is left waiting
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      starve_cnt_r <= 4'd0;
    end else if (!bus.if_req_valid || grant_if_s) begin
      starve_cnt_r <= 4'd0;
    end else if (grant_d_s) begin
      starve_cnt_r <= sat_inc4(starve_cnt_r);
    end
  end

  assign starve_force_s = (starve_cnt_r >= 4'(STARVE_MAX));
`else
  assign starve_force_s = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_r <= ARB_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Next-state logic; reads skip WAIT entirely when RD_LAT is 1
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_IDLE:  state_nxt_s = accept_s ? ARB_ISSUE : ARB_IDLE;
      ARB_ISSUE: state_nxt_s = (we_r || (lat_cnt_r == LAT_ZERO)) ? ARB_RESP : ARB_WAIT;
      ARB_WAIT:  state_nxt_s = (lat_cnt_r == LAT_ZERO) ? ARB_RESP : ARB_WAIT;
      ARB_RESP:  state_nxt_s = ARB_IDLE;
      default:   state_nxt_s = ARB_IDLE;
    endcase
  end

  // Arbitration and response-strobe decode
  always_comb begin
    grant_d_s  = 1'b0;
    grant_if_s = 1'b0;
    to_resp_s  = (state_r != ARB_RESP) && (state_nxt_s == ARB_RESP);
    if ((state_r == ARB_IDLE) && Reset_n) begin
      if (bus.d_req_valid && !(starve_force_s && bus.if_req_valid && !bus.if_flush)) begin
        grant_d_s = 1'b1;
      end else if (bus.if_req_valid && !bus.if_flush) begin
        grant_if_s = 1'b1;
      end else begin
        grant_d_s  = 1'b0;
        grant_if_s = 1'b0;
      end
    end else begin
      grant_d_s  = 1'b0;
      grant_if_s = 1'b0;
    end
  end

  assign accept_s = grant_d_s | grant_if_s;
  assign d_wr_s   = grant_d_s & bus.d_req_we;

  // Transaction owner, latency countdown and fetch-kill flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      owner_r   <= OWN_IF;
      we_r      <= 1'b0;
      lat_cnt_r <= LAT_ZERO;
      kill_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        owner_r   <= grant_d_s ? OWN_DATA : OWN_IF;
        we_r      <= d_wr_s;
        lat_cnt_r <= LAT_INIT;
      end else if (((state_r == ARB_ISSUE) || (state_r == ARB_WAIT)) && (lat_cnt_r != LAT_ZERO)) begin
        lat_cnt_r <= lat_cnt_r - LAT_ONE;
      end
      if (state_r == ARB_RESP) begin
        kill_r <= 1'b0;
      end else if ((owner_r == OWN_IF) && ((state_r == ARB_ISSUE) || (state_r == ARB_WAIT)) && bus.if_flush) begin
        kill_r <= 1'b1;
      end
    end
  end

  // Memory command: all fields live for exactly the ISSUE cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_addr_r    <= {ADDR_W{1'b0}};
      mem_rd_en_r   <= 1'b0;
      mem_wr_en_r   <= 1'b0;
      mem_wr_strb_r <= 4'd0;
      mem_wr_data_r <= {DATA_W{1'b0}};
    end else begin
      mem_addr_r    <= {ADDR_W{1'b0}};
      mem_rd_en_r   <= 1'b0;
      mem_wr_en_r   <= 1'b0;
      mem_wr_strb_r <= 4'd0;
      mem_wr_data_r <= {DATA_W{1'b0}};
      if (accept_s) begin
        mem_addr_r <= grant_d_s ? bus.d_req_addr : bus.if_req_addr;
        if (d_wr_s) begin
          mem_wr_en_r   <= 1'b1;
          mem_wr_strb_r <= bus.d_req_wstrb;
          mem_wr_data_r <= bus.d_req_wdata;
        end else begin
          mem_rd_en_r <= 1'b1;
        end
      end
    end
  end

  // Response strobes; read data captured on the cycle before RESP
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      if_rsp_valid_r <= 1'b0;
      if_rsp_data_r  <= {DATA_W{1'b0}};
      d_rsp_valid_r  <= 1'b0;
      d_rsp_data_r   <= {DATA_W{1'b0}};
    end else begin
      if_rsp_valid_r <= 1'b0;
      if_rsp_data_r  <= {DATA_W{1'b0}};
      d_rsp_valid_r  <= 1'b0;
      d_rsp_data_r   <= {DATA_W{1'b0}};
      if (to_resp_s) begin
        if (we_r) begin
          d_rsp_valid_r <= 1'b1;
        end else if (owner_r == OWN_DATA) begin
          d_rsp_valid_r <= 1'b1;
          d_rsp_data_r  <= bus.mem_rd_data;
        end else if (!kill_r && !bus.if_flush) begin
          if_rsp_valid_r <= 1'b1;
          if_rsp_data_r  <= bus.mem_rd_data;
        end
      end
    end
  end

  assign bus.if_req_ready = grant_if_s;
  assign bus.d_req_ready  = grant_d_s;
  // A redirect arriving in the RESP cycle itself still kills the fetch strobe
  assign bus.if_rsp_valid = if_rsp_valid_r & ~bus.if_flush;
  assign bus.if_rsp_data  = if_rsp_data_r;
  assign bus.d_rsp_valid  = d_rsp_valid_r;
  assign bus.d_rsp_data   = d_rsp_data_r;
  assign bus.mem_addr     = mem_addr_r;
  assign bus.mem_rd_en    = mem_rd_en_r;
  assign bus.mem_wr_en    = mem_wr_en_r;
  assign bus.mem_wr_strb  = mem_wr_strb_r;
  assign bus.mem_wr_data  = mem_wr_data_r;
  assign busy             = (state_r != ARB_IDLE);

endmodule
